// File: rtl/csi_rx_clk_mon.sv
// Byte-clock monitor for a CSI receiver: qualifies each asynchronous byte clock, measures
// its edge rate per window, and holds that lane's ISERDES in reset while it is unusable.
module csi_rx_clk_mon #(
  parameter int  NUM_CH     = 2,
  parameter int  TIMEOUT    = 10,
  parameter int  GOOD_EDGES = 3,
  parameter int  WIN_LEN    = 256,
  parameter int  MIN_EDGES  = 8,
  parameter int  MAX_EDGES  = 200,
  localparam int CW         = $clog2(WIN_LEN) + 1
) (
  input  logic                 ref_clock,
  input  logic                 reset_in,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    byte_clock,
  input  logic                 clr_sticky,
  output logic [NUM_CH-1:0]    clk_ok,
  output logic [NUM_CH-1:0]    reset_out,
  output logic [NUM_CH*CW-1:0] edge_cnt,
  output logic                 cnt_valid,
  output logic [NUM_CH-1:0]    lost_sticky
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int QW = $clog2(GOOD_EDGES + 1);
  localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

  typedef enum logic [1:0] {
    ST_LOST,
    ST_QUALIFY,
    ST_LOCKED
  } state_t;

  logic [WW-1:0] win_cnt;
  logic          win_term;

  assign win_term = (win_cnt == WW'(WIN_LEN - 1));

  // NOTE: reset is synchronous, so it lives inside the clocked branch, and all state
  // updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ref_clock) begin
    if (reset_in) begin
      win_cnt   <= '0;
      cnt_valid <= 1'b0;
    end else begin
      win_cnt   <= win_term ? '0 : win_cnt + 1'b1;
      cnt_valid <= win_term;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [2:0]    sync;
    logic          toggle, rise, timeout;
    logic [IW-1:0] idle;
    logic [QW-1:0] qcnt;
    logic [CW-1:0] acc, acc_close, cnt_q;
    logic          armed, range_fault, qual_done, drop;
    state_t        state, state_nxt;
    logic          clk_ok_q, reset_out_q, sticky_q;
    logic          clk_ok_d, reset_out_d, sticky_set;

    assign toggle    = sync[1] ^ sync[2];
    assign rise      = sync[1] & ~sync[2];
    assign timeout   = (idle == IW'(TIMEOUT));
    assign drop      = timeout || !enable;
    assign acc_close = (rise && (acc != {CW{1'b1}})) ? acc + 1'b1 : acc;
    assign qual_done = (state == ST_QUALIFY) && rise && (qcnt == QW'(GOOD_EDGES - 1));
    // Only windows that started after the first closure in LOCKED are range-checked.
    assign range_fault = (state == ST_LOCKED) && win_term && armed &&
                         ((int'(acc_close) < MIN_EDGES) || (int'(acc_close) > MAX_EDGES));

    always_ff @(posedge ref_clock) begin
      if (reset_in) begin
        sync  <= '0;
        idle  <= '0;
        acc   <= '0;
        cnt_q <= '0;
        qcnt  <= '0;
        armed <= 1'b0;
      end else begin
        sync <= {sync[1:0], byte_clock[i]};
        if (toggle)
          idle <= '0;
        else if (!timeout)
          idle <= idle + 1'b1;
        acc <= win_term ? '0 : acc_close;
        if (win_term)
          cnt_q <= acc_close;
        if (state != ST_QUALIFY)
          qcnt <= '0;
        else if (rise)
          qcnt <= qcnt + 1'b1;
        if (state != ST_LOCKED)
          armed <= 1'b0;
        else if (win_term)
          armed <= 1'b1;
      end
    end

    always_ff @(posedge ref_clock) begin
      if (reset_in) begin
        state       <= ST_LOST;
        clk_ok_q    <= 1'b0;
        reset_out_q <= 1'b1;
        sticky_q    <= 1'b0;
      end else begin
        state       <= state_nxt;
        clk_ok_q    <= clk_ok_d;
        reset_out_q <= reset_out_d;
        if (sticky_set)
          sticky_q <= 1'b1;
        else if (clr_sticky)
          sticky_q <= 1'b0;
      end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
      state_nxt = state;
      case (state)
        ST_LOST:    if (!drop && toggle) state_nxt = ST_QUALIFY;
        ST_QUALIFY: if (drop) state_nxt = ST_LOST;
                    else if (qual_done) state_nxt = ST_LOCKED;
        ST_LOCKED:  if (drop || range_fault) state_nxt = ST_LOST;
        default:    state_nxt = ST_LOST;
      endcase
    end

    // Outputs decode the next state so the registered flags line up with the state flop.
    always_comb begin
      clk_ok_d    = (state_nxt == ST_LOCKED);
      reset_out_d = (state_nxt != ST_LOCKED);
      sticky_set  = (state == ST_LOCKED) && (timeout || range_fault);
    end

    assign clk_ok[i]               = clk_ok_q;
    assign reset_out[i]            = reset_out_q;
    assign lost_sticky[i]          = sticky_q;
    assign edge_cnt[i*CW +: CW]    = cnt_q;
  end

endmodule

// File: tb/tb_csi_rx_clk_mon.sv
// Directed bench for csi_rx_clk_mon: a default instance plus one with MIN_EDGES=20.
// Byte clocks are generated from ref-cycle counters; expected latencies are hand-derived.
module tb_csi_rx_clk_mon;
  localparam int CW = 9;

  logic            ref_clock = 1'b0;
  logic            reset_in, enable, clr_sticky;
  logic [2:0]      bc;
  logic [1:0]      clk_ok, reset_out, lost_sticky;
  logic [1:0]      clk_ok_m, reset_out_m, lost_sticky_m;
  logic [2*CW-1:0] edge_cnt, edge_cnt_m;
  logic            cnt_valid, cnt_valid_m;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int r, n, w;
  int cnt[3];
  int per[3];
  bit run[3];

  always #5 ref_clock = ~ref_clock;

  csi_rx_clk_mon dut (
    .ref_clock(ref_clock), .reset_in(reset_in), .enable(enable),
    .byte_clock(bc[1:0]), .clr_sticky(clr_sticky), .clk_ok(clk_ok),
    .reset_out(reset_out), .edge_cnt(edge_cnt), .cnt_valid(cnt_valid),
    .lost_sticky(lost_sticky)
  );

  csi_rx_clk_mon #(.MIN_EDGES(20)) dut_m (
    .ref_clock(ref_clock), .reset_in(reset_in), .enable(enable),
    .byte_clock({bc[2], 1'b0}), .clr_sticky(clr_sticky), .clk_ok(clk_ok_m),
    .reset_out(reset_out_m), .edge_cnt(edge_cnt_m), .cnt_valid(cnt_valid_m),
    .lost_sticky(lost_sticky_m)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One ref cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge ref_clock);
    #1;
    cyc++;
    for (int c = 0; c < 3; c++) begin
      if (run[c]) begin
        cnt[c]++;
        bc[c] = ((cnt[c] % per[c]) < (per[c] / 2));
      end
    end
  endtask

  // The next tick drives the high phase of the clock.
  task automatic start_clk(input int c, input int p);
    per[c] = p;
    cnt[c] = -1;
    run[c] = 1'b1;
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 300; k++) begin
      tick();
      if (cnt_valid === 1'b1) break;
    end
  endtask

  // Stops channel 0 right after the tick that drove a rising edge.
  task automatic stop0_high();
    for (int k = 0; k < 8; k++) begin
      tick();
      if (cnt[0] % 8 == 0) break;
    end
    run[0] = 1'b0;
  endtask

  initial begin
    reset_in   = 1'b1;
    enable     = 1'b0;
    clr_sticky = 1'b0;
    bc         = '0;
    for (int c = 0; c < 3; c++) begin
      run[c] = 1'b0;
      cnt[c] = 0;
      per[c] = 2;
    end

    repeat (3) tick();
    check("rst_reset_out", reset_out, 2'b11);
    check("rst_clk_ok", clk_ok, 2'b00);
    check("rst_edge_cnt", edge_cnt, 0);
    check("rst_cnt_valid", cnt_valid, 0);
    check("rst_sticky", lost_sticky, 2'b00);

    // Lock: the first rise (idle counter fresh from reset) enters QUALIFY, three more rises
    // are counted; rise driven after edge n is seen in the cycle after edge n+2.
    // Release at r, rises driven at r+1, r+9, r+17, r+25 -> LOCKED visible at r+28.
    reset_in = 1'b0;
    enable   = 1'b1;
    start_clk(0, 8);
    start_clk(1, 10);
    r = cyc;
    for (int k = 0; k < 60; k++) begin
      if (reset_out[0] === 1'b0) break;
      tick();
    end
    check("lock0_latency", cyc - r, 28);
    check("lock0_clk_ok", clk_ok[0], 1);

    // Window restarts at release, so cnt_valid appears at r+256 and r+512; 32 rises each.
    wait_valid();
    check("win1_time", cyc - r, 256);
    check("win1_edges0", edge_cnt[CW-1:0], 32);
    tick();
    check("valid_pulse_low", cnt_valid, 0);
    wait_valid();
    check("win2_time", cyc - r, 512);
    check("win2_edges0", edge_cnt[CW-1:0], 32);
    check("win2_both_ok", clk_ok, 2'b11);

    // Held high: last toggle seen after n+2, idle hits TIMEOUT after n+13, LOST at n+14.
    stop0_high();
    n = cyc;
    repeat (13) tick();
    check("to_still_locked", reset_out[0], 0);
    tick();
    check("to_reset_out0", reset_out[0], 1);
    check("to_clk_ok0", clk_ok[0], 0);
    check("to_sticky0", lost_sticky[0], 1);
    check("to_ch1_clk_ok", clk_ok[1], 1);
    check("to_ch1_reset_out", reset_out[1], 0);
    check("to_ch1_sticky", lost_sticky[1], 0);

    // Period 18 on the MIN_EDGES=20 instance, started after closure W: lock near W+58,
    // first closure (15 rises) ignored, second closure holds 14 rises -> LOST.
    for (int k = 0; k < 300; k++) begin
      tick();
      if (cnt_valid_m === 1'b1) break;
    end
    w = cyc;
    start_clk(2, 18);
    wait_valid();
    check("rng_win_a_time", cyc - w, 256);
    check("rng_win_a_edges", edge_cnt_m[2*CW-1:CW], 15);
    check("rng_first_ignored", clk_ok_m[1], 1);
    wait_valid();
    check("rng_win_b_edges", edge_cnt_m[2*CW-1:CW], 14);
    check("rng_clk_ok", clk_ok_m[1], 0);
    check("rng_reset_out", reset_out_m[1], 1);
    check("rng_sticky", lost_sticky_m[1], 1);
    run[2] = 1'b0;

    // Sticky clear alone, then a timeout coinciding with clr_sticky.
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("clr_alone_a", lost_sticky[0], 0);
    start_clk(0, 8);
    for (int k = 0; k < 100; k++) begin
      if (clk_ok[0] === 1'b1) break;
      tick();
    end
    check("relock0", clk_ok[0], 1);
    stop0_high();
    repeat (13) tick();
    check("clr_to_still_locked", reset_out[0], 0);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("clr_to_lost", reset_out[0], 1);
    check("clr_set_wins", lost_sticky[0], 1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("clr_alone_b", lost_sticky[0], 0);

    // Enable drop on the locked channel 1.
    check("en_pre_locked1", clk_ok[1], 1);
    enable = 1'b0;
    tick();
    check("en_reset_out1", reset_out[1], 1);
    check("en_clk_ok1", clk_ok[1], 0);
    check("en_sticky", lost_sticky, 2'b00);
    enable = 1'b1;

    // Reset mid-window with both channels locked, then relock from fresh rises.
    start_clk(0, 8);
    for (int k = 0; k < 120; k++) begin
      if (clk_ok === 2'b11) break;
      tick();
    end
    check("pre_rst_both_ok", clk_ok, 2'b11);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (cnt[0] % 8 == 4) break;
    end
    run[0]   = 1'b0;
    reset_in = 1'b1;
    tick();
    check("mid_rst_reset_out", reset_out, 2'b11);
    check("mid_rst_clk_ok", clk_ok, 2'b00);
    check("mid_rst_edge_cnt", edge_cnt, 0);
    check("mid_rst_valid", cnt_valid, 0);
    check("mid_rst_sticky_m", lost_sticky_m, 2'b00);
    check("mid_rst_reset_out_m", reset_out_m, 2'b11);
    reset_in = 1'b0;
    start_clk(0, 8);
    r = cyc;
    for (int k = 0; k < 60; k++) begin
      if (reset_out[0] === 1'b0) break;
      tick();
    end
    check("relock_latency", cyc - r, 28);
    wait_valid();
    check("post_rst_win_time", cyc - r, 256);
    check("post_rst_edges0", edge_cnt[CW-1:0], 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
